// File: rtl/idecode.sv
// idecode: instruction decode stage between ifetch and execute.
// Decodes fields and control, reads the 32x32 register file with write-through
// bypass, resolves branches/jumps, detects load-use and branch-operand hazards
// and registers one decoded bundle per cycle.
//
// Handshake: this stage has no valid/ready pair. Upstream, stall_o=1 tells
// ifetch to hold inst_i/inst_addr_i at the next edge and branch_o=1 redirects
// it. Downstream, stall_i=1 from execute freezes every output and the FSM
// state. valid_o=0 marks a bubble.
module idecode #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inst_i,
    input  logic [AW-1:0] inst_addr_i,
    input  logic          stall_i,
    input  logic          wb_we_i,
    input  logic [4:0]    wb_rd_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          hz_we_i,
    input  logic [4:0]    hz_rd_i,
    output logic          branch_o,
    output logic [AW-1:0] branch_addr_o,
    output logic          stall_o,
    output logic          valid_o,
    output logic [5:0]    op_o,
    output logic [4:0]    rd_o,
    output logic [DW-1:0] rs1_data_o,
    output logic [DW-1:0] rs2_data_o,
    output logic [31:0]   imm_o,
    output logic [AW-1:0] pc_o,
    output logic          reg_we_o,
    output logic          mem_re_o,
    output logic          mem_we_o,
    output logic          illegal_o,
    output logic          state_o
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h18;
    localparam logic [5:0] OP_BNE  = 6'h19;
    localparam logic [5:0] OP_JMP  = 6'h1A;

    typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

    state_t state_q, state_nx;

    logic [DW-1:0] rf [32];

    // Instruction fields
    logic [5:0]  op_f;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [31:0] imm_sext;

    assign op_f     = inst_i[31:26];
    assign rd_f     = inst_i[25:21];
    assign rs1_f    = inst_i[20:16];
    assign rs2_f    = inst_i[15:11];
    assign imm_sext = {{16{inst_i[15]}}, inst_i[15:0]};

    // Decoded control
    logic [5:0] d_op;
    logic [4:0] d_rd;
    logic       d_we, d_re, d_mwe, d_ill;
    logic       use_rs1, use_rs2, is_br, is_bne, is_jmp;

    // Opcode decode; unknown opcodes become a NOP flagged illegal
    always_comb begin
        d_op    = op_f;
        d_we    = 1'b0;
        d_re    = 1'b0;
        d_mwe   = 1'b0;
        d_ill   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_br   = 1'b0;
        is_bne  = 1'b0;
        is_jmp  = 1'b0;
        case (op_f)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                d_we    = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_ADDI: begin
                d_we    = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_LD: begin
                d_we    = 1'b1;
                d_re    = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_ST: begin
                d_mwe   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                is_br   = 1'b1;
                is_bne  = (op_f == OP_BNE);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_JMP: is_jmp = 1'b1;
            default: begin
                d_op  = OP_NOP;
                d_ill = 1'b1;
            end
        endcase
        if (rd_f == 5'd0) d_we = 1'b0;
        d_rd = d_ill ? 5'd0 : rd_f;
    end

    // Register file reads: r0 is hardwired zero, same-cycle writeback bypasses
    logic [DW-1:0] rs1_rd, rs2_rd;

    always_comb begin
        rs1_rd = rf[rs1_f];
        rs2_rd = rf[rs2_f];
        if (wb_we_i && wb_rd_i == rs1_f) rs1_rd = wb_data_i;
        if (wb_we_i && wb_rd_i == rs2_f) rs2_rd = wb_data_i;
        if (rs1_f == 5'd0) rs1_rd = '0;
        if (rs2_f == 5'd0) rs2_rd = '0;
    end

    // Hazards, branch resolution and the ifetch control outputs
    logic load_use, br_hz, hazard, taken, bubble;

    always_comb begin
        load_use = valid_o && mem_re_o && (rd_o != 5'd0) &&
                   ((use_rs1 && rs1_f == rd_o) || (use_rs2 && rs2_f == rd_o));
        br_hz    = is_br &&
                   (((rs1_f != 5'd0) &&
                     ((valid_o && reg_we_o && rs1_f == rd_o) || (hz_we_i && rs1_f == hz_rd_i))) ||
                    ((rs2_f != 5'd0) &&
                     ((valid_o && reg_we_o && rs2_f == rd_o) || (hz_we_i && rs2_f == hz_rd_i))));
        // The wrong-path word in SQUASH is discarded, so it cannot cause a hazard
        hazard   = (state_q == RUN) && (load_use || br_hz);
        taken    = (state_q == RUN) && !hazard && !stall_i &&
                   (is_jmp || (is_br && ((rs1_rd == rs2_rd) != is_bne)));
        bubble   = (state_q == SQUASH) || hazard;
        stall_o  = stall_i || hazard;
        branch_o = taken;
        branch_addr_o = is_jmp ? inst_i[AW-1:0]
                               : inst_addr_i + AW'(1) + imm_sext[AW-1:0];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_nx;
    end

    // FSM next state: a taken branch squashes exactly one unstalled cycle
    always_comb begin
        state_nx = state_q;
        if (!stall_i) begin
            case (state_q)
                RUN:     if (taken) state_nx = SQUASH;
                SQUASH:  state_nx = RUN;
                default: state_nx = RUN;
            endcase
        end
    end

    assign state_o = (state_q == SQUASH);

    // Register file write port; r0 never stored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we_i && wb_rd_i != 5'd0) begin
            rf[wb_rd_i] <= wb_data_i;
        end
    end

    // Decoded bundle register: hold on stall_i, bubble on hazard/squash
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o    <= 1'b0;
            op_o       <= '0;
            rd_o       <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            pc_o       <= '0;
            reg_we_o   <= 1'b0;
            mem_re_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (!stall_i) begin
            if (bubble) begin
                valid_o    <= 1'b0;
                op_o       <= '0;
                rd_o       <= '0;
                rs1_data_o <= '0;
                rs2_data_o <= '0;
                imm_o      <= '0;
                pc_o       <= '0;
                reg_we_o   <= 1'b0;
                mem_re_o   <= 1'b0;
                mem_we_o   <= 1'b0;
                illegal_o  <= 1'b0;
            end else begin
                valid_o    <= 1'b1;
                op_o       <= d_op;
                rd_o       <= d_rd;
                rs1_data_o <= rs1_rd;
                rs2_data_o <= rs2_rd;
                imm_o      <= imm_sext;
                pc_o       <= inst_addr_i;
                reg_we_o   <= d_we;
                mem_re_o   <= d_re;
                mem_we_o   <= d_mwe;
                illegal_o  <= d_ill;
            end
        end
    end

endmodule

// File: tb/tb_idecode.sv
// tb_idecode: directed bench for idecode. A table of single-cycle decode
// vectors, then hand-written sequences for load-use, taken branch, branch
// operand hazard, reset during SQUASH and execute back-pressure.
module tb_idecode;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk, rst;
    logic [DW-1:0] inst_i;
    logic [AW-1:0] inst_addr_i;
    logic          stall_i, wb_we_i, hz_we_i;
    logic [4:0]    wb_rd_i, hz_rd_i;
    logic [DW-1:0] wb_data_i;
    logic          branch_o, stall_o, valid_o, reg_we_o, mem_re_o, mem_we_o, illegal_o, state_o;
    logic [AW-1:0] branch_addr_o, pc_o;
    logic [5:0]    op_o;
    logic [4:0]    rd_o;
    logic [DW-1:0] rs1_data_o, rs2_data_o;
    logic [31:0]   imm_o;

    int checks = 0;
    int failures = 0;

    idecode #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .stall_i(stall_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .hz_we_i(hz_we_i), .hz_rd_i(hz_rd_i), .branch_o(branch_o),
        .branch_addr_o(branch_addr_o), .stall_o(stall_o), .valid_o(valid_o),
        .op_o(op_o), .rd_o(rd_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .pc_o(pc_o), .reg_we_o(reg_we_o), .mem_re_o(mem_re_o),
        .mem_we_o(mem_we_o), .illegal_o(illegal_o), .state_o(state_o)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [15:0] addr;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        we;
        logic        re;
        logic        mwe;
        logic        ill;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bundle(input string tag, input logic v, input logic [5:0] op,
                              input logic [4:0] rd, input logic [15:0] pc,
                              input logic we, input logic re, input logic mwe, input logic ill);
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".op"}, 32'(op_o), 32'(op));
        chk({tag, ".rd"}, 32'(rd_o), 32'(rd));
        chk({tag, ".pc"}, 32'(pc_o), 32'(pc));
        chk({tag, ".reg_we"}, 32'(reg_we_o), 32'(we));
        chk({tag, ".mem_re"}, 32'(mem_re_o), 32'(re));
        chk({tag, ".mem_we"}, 32'(mem_we_o), 32'(mwe));
        chk({tag, ".illegal"}, 32'(illegal_o), 32'(ill));
    endtask

    initial begin
        rst = 1'b0;
        inst_i = '0; inst_addr_i = '0; stall_i = 1'b0;
        wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        hz_we_i = 1'b0; hz_rd_i = '0;

        //             inst                              addr   wbwe rd  wbdata        op     rd  d1            d2            imm           we re mwe ill
        vecs[0]  = '{enc_i(6'h08, 5'd1, 5'd0, 16'd5),    16'd0,  0, 5'd0, 32'h0,        6'h08, 1, 32'h0,        32'h0,        32'h5,        1, 0, 0, 0};
        vecs[1]  = '{enc_r(6'h01, 5'd3, 5'd2, 5'd0),     16'd1,  1, 5'd2, 32'h1234,     6'h01, 3, 32'h1234,     32'h0,        32'h0,        1, 0, 0, 0};
        vecs[2]  = '{enc_r(6'h02, 5'd4, 5'd2, 5'd2),     16'd2,  1, 5'd0, 32'hdead,     6'h02, 4, 32'h1234,     32'h1234,     32'h1000,     1, 0, 0, 0};
        vecs[3]  = '{enc_r(6'h03, 5'd0, 5'd2, 5'd0),     16'd3,  1, 5'd5, 32'hff00ff00, 6'h03, 0, 32'h1234,     32'h0,        32'h0,        0, 0, 0, 0};
        vecs[4]  = '{enc_r(6'h04, 5'd6, 5'd5, 5'd2),     16'd4,  1, 5'd7, 32'haa,       6'h04, 6, 32'hff00ff00, 32'h1234,     32'h1000,     1, 0, 0, 0};
        vecs[5]  = '{enc_r(6'h05, 5'd7, 5'd7, 5'd5),     16'd5,  0, 5'd0, 32'h0,        6'h05, 7, 32'haa,       32'hff00ff00, 32'h2800,     1, 0, 0, 0};
        vecs[6]  = '{enc_i(6'h08, 5'd8, 5'd1, 16'hffff), 16'd6,  0, 5'd0, 32'h0,        6'h08, 8, 32'h0,        32'h0,        32'hffffffff, 1, 0, 0, 0};
        vecs[7]  = '{enc_r(6'h11, 5'd9, 5'd2, 5'd5),     16'd7,  0, 5'd0, 32'h0,        6'h11, 9, 32'h1234,     32'hff00ff00, 32'h2800,     0, 0, 1, 0};
        vecs[8]  = '{enc_i(6'h10, 5'd9, 5'd2, 16'd4),    16'd8,  0, 5'd0, 32'h0,        6'h10, 9, 32'h1234,     32'h0,        32'h4,        1, 1, 0, 0};
        vecs[9]  = '{32'h0,                              16'd9,  0, 5'd0, 32'h0,        6'h00, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0};
        vecs[10] = '{enc_i(6'h3f, 5'd0, 5'd0, 16'd0),    16'd10, 0, 5'd0, 32'h0,        6'h00, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 1};
        vecs[11] = '{enc_r(6'h18, 5'd0, 5'd2, 5'd5),     16'd11, 0, 5'd0, 32'h0,        6'h18, 0, 32'h1234,     32'hff00ff00, 32'h2800,     0, 0, 0, 0};

        // Reset state
        step();
        step();
        chk_bundle("reset", 0, 6'h00, 5'd0, 16'h0, 0, 0, 0, 0);
        chk("reset.rs1_data", rs1_data_o, 32'h0);
        chk("reset.rs2_data", rs2_data_o, 32'h0);
        chk("reset.imm", imm_o, 32'h0);
        chk("reset.branch", 32'(branch_o), 32'h0);
        chk("reset.stall", 32'(stall_o), 32'h0);
        chk("reset.state", 32'(state_o), 32'h0);
        rst = 1'b1;

        // Table of single-cycle decodes, including bypass and r0 write cases
        for (int i = 0; i < 12; i++) begin
            inst_i = vecs[i].inst;
            inst_addr_i = vecs[i].addr;
            wb_we_i = vecs[i].wb_we;
            wb_rd_i = vecs[i].wb_rd;
            wb_data_i = vecs[i].wb_data;
            #1;
            chk($sformatf("v%0d.stall", i), 32'(stall_o), 32'h0);
            chk($sformatf("v%0d.branch", i), 32'(branch_o), 32'h0);
            step();
            wb_we_i = 1'b0;
            chk_bundle($sformatf("v%0d", i), 1, vecs[i].op, vecs[i].rd, vecs[i].addr,
                       vecs[i].we, vecs[i].re, vecs[i].mwe, vecs[i].ill);
            chk($sformatf("v%0d.rs1_data", i), rs1_data_o, vecs[i].d1);
            chk($sformatf("v%0d.rs2_data", i), rs2_data_o, vecs[i].d2);
            chk($sformatf("v%0d.imm", i), imm_o, vecs[i].imm);
        end

        // Load-use: LD r4 then ADD r5,r4,r4 -> one stall cycle and one bubble
        inst_i = enc_i(6'h10, 5'd4, 5'd2, 16'd0);
        inst_addr_i = 16'h20;
        step();
        inst_i = enc_r(6'h01, 5'd5, 5'd4, 5'd4);
        inst_addr_i = 16'h21;
        #1;
        chk("lu.stall", 32'(stall_o), 32'h1);
        chk("lu.branch", 32'(branch_o), 32'h0);
        step();
        chk("lu.bubble_valid", 32'(valid_o), 32'h0);
        chk("lu.bubble_we", 32'(reg_we_o), 32'h0);
        chk("lu.stall_cleared", 32'(stall_o), 32'h0);
        step();
        chk_bundle("lu.add", 1, 6'h01, 5'd5, 16'h21, 1, 0, 0, 0);

        // Taken BEQ r0,r0,+3 at 0x10 -> target 0x14, next word squashed
        inst_i = enc_i(6'h18, 5'd0, 5'd0, 16'd3);
        inst_addr_i = 16'h10;
        #1;
        chk("beq.branch", 32'(branch_o), 32'h1);
        chk("beq.target", 32'(branch_addr_o), 32'h14);
        chk("beq.stall", 32'(stall_o), 32'h0);
        step();
        chk_bundle("beq.out", 1, 6'h18, 5'd0, 16'h10, 0, 0, 0, 0);
        chk("beq.state", 32'(state_o), 32'h1);
        inst_i = enc_i(6'h08, 5'd9, 5'd0, 16'd7);
        inst_addr_i = 16'h11;
        #1;
        chk("squash.branch", 32'(branch_o), 32'h0);
        chk("squash.stall", 32'(stall_o), 32'h0);
        step();
        chk("squash.valid", 32'(valid_o), 32'h0);
        chk("squash.state", 32'(state_o), 32'h0);
        inst_addr_i = 16'h14;
        step();
        chk_bundle("target.addi", 1, 6'h08, 5'd9, 16'h14, 1, 0, 0, 0);
        chk("target.imm", imm_o, 32'h7);

        // BNE r6,r7 blocked by an EX->WB writer of r6 until it clears
        inst_i = enc_r(6'h19, 5'd0, 5'd6, 5'd7);
        inst_addr_i = 16'h30;
        hz_we_i = 1'b1;
        hz_rd_i = 5'd6;
        #1;
        chk("bhz.stall0", 32'(stall_o), 32'h1);
        chk("bhz.branch0", 32'(branch_o), 32'h0);
        step();
        chk("bhz.bubble0", 32'(valid_o), 32'h0);
        chk("bhz.stall1", 32'(stall_o), 32'h1);
        chk("bhz.branch1", 32'(branch_o), 32'h0);
        step();
        chk("bhz.bubble1", 32'(valid_o), 32'h0);
        hz_we_i = 1'b0;
        #1;
        chk("bhz.stall_clear", 32'(stall_o), 32'h0);
        chk("bhz.branch", 32'(branch_o), 32'h1);
        chk("bhz.target", 32'(branch_addr_o), 32'h3831);
        step();
        chk_bundle("bhz.out", 1, 6'h19, 5'd0, 16'h30, 0, 0, 0, 0);
        chk("bhz.state", 32'(state_o), 32'h1);

        // Asynchronous reset while in SQUASH clears outputs immediately
        inst_i = 32'h0;
        inst_addr_i = 16'h31;
        #2;
        rst = 1'b0;
        #1;
        chk_bundle("rst_sq", 0, 6'h00, 5'd0, 16'h0, 0, 0, 0, 0);
        chk("rst_sq.state", 32'(state_o), 32'h0);
        step();
        rst = 1'b1;

        // Register file was cleared by reset
        inst_i = enc_r(6'h01, 5'd3, 5'd2, 5'd5);
        inst_addr_i = 16'h3f;
        step();
        chk("rfclr.rs1", rs1_data_o, 32'h0);
        chk("rfclr.rs2", rs2_data_o, 32'h0);

        // Execute back-pressure holds outputs and overrides a taken JMP
        inst_i = enc_i(6'h08, 5'd1, 5'd0, 16'h55);
        inst_addr_i = 16'h40;
        step();
        chk("hold.pre_imm", imm_o, 32'h55);
        stall_i = 1'b1;
        inst_i = enc_i(6'h1a, 5'd0, 5'd0, 16'h100);
        inst_addr_i = 16'h41;
        #1;
        chk("hold.stall", 32'(stall_o), 32'h1);
        chk("hold.branch", 32'(branch_o), 32'h0);
        step();
        chk_bundle("hold.out", 1, 6'h08, 5'd1, 16'h40, 1, 0, 0, 0);
        chk("hold.imm", imm_o, 32'h55);
        chk("hold.state", 32'(state_o), 32'h0);
        stall_i = 1'b0;
        #1;
        chk("jmp.branch", 32'(branch_o), 32'h1);
        chk("jmp.target", 32'(branch_addr_o), 32'h100);
        chk("jmp.stall", 32'(stall_o), 32'h0);
        step();
        chk_bundle("jmp.out", 1, 6'h1a, 5'd0, 16'h41, 0, 0, 0, 0);
        chk("jmp.state", 32'(state_o), 32'h1);
        inst_i = 32'h0;
        inst_addr_i = 16'h42;
        #1;
        chk("jmp.sq_branch", 32'(branch_o), 32'h0);
        step();
        chk("jmp.sq_valid", 32'(valid_o), 32'h0);
        chk("jmp.sq_state", 32'(state_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idecode.md
# idecode

Instruction decode stage directly downstream of `ifetch`. Takes the fetched word and its address, and decodes fields and control. Reads a 32x32 register file that has a writeback port. Resolves branches and jumps, and drives `branch`/`branch_addr` back to `ifetch`. Detects load-use and branch-operand hazards, and drives `stall` to `ifetch`. Outputs one registered decoded bundle per cycle to the execute stage.

## Interface
- `AW`, 16: instruction address width (word addressed).
- `DW`, 32: data/instruction width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst_i` in DW: instruction from `ifetch`. Held stable by `ifetch` while `stall_o`=1.
- `inst_addr_i` in AW: address of `inst_i`.
- `stall_i` in 1: execute busy. Hold all outputs and decode state.
- `wb_we_i` in 1: register file write enable.
- `wb_rd_i` in 5: writeback register number.
- `wb_data_i` in DW: writeback data.
- `hz_we_i` in 1: the instruction in the EX→WB path writes a register.
- `hz_rd_i` in 5: destination register of that instruction.
- `branch_o` out 1: redirect `ifetch` (to `branch_i`).
- `branch_addr_o` out AW: redirect target.
- `stall_o` out 1: freeze `ifetch` (to `stall_i`).
- `valid_o`, `op_o[5:0]`, `rd_o[4:0]`, `rs1_data_o`, `rs2_data_o`, `imm_o[31:0]`, `pc_o[AW-1:0]`, `reg_we_o`, `mem_re_o`, `mem_we_o`, `illegal_o`: registered decoded bundle to execute.

## Operation
- Instruction format: op=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], imm16=[15:0]. `imm_o` is imm16 sign-extended.
- Opcodes:
  - 0x00 NOP.
  - R-type, reg_we=1: 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR.
  - 0x08 ADDI, reg_we=1.
  - 0x10 LD: reg_we=1, mem_re=1.
  - 0x11 ST: mem_we=1, stores rs2.
  - 0x18 BEQ, 0x19 BNE: target = inst_addr_i + 1 + imm16, truncated to AW.
  - 0x1A JMP: target = imm16[AW-1:0].
  - Any other opcode is illegal: decoded as NOP with `illegal_o`=1.
- rd=0 forces reg_we=0.
- Register file:
  - r0 reads 0 and ignores writes.
  - A write in the same cycle as a read of the same register returns `wb_data_i` (write-through bypass).
- Hazard stall (`stall_o`=1, combinational), when either holds:
  - Load-use: `valid_o`&`mem_re_o` and rd_o≠0 equals a source register used by the current instruction.
  - Branch operand: current op is BEQ/BNE and rs1 or rs2 (nonzero) equals rd_o (`valid_o`&`reg_we_o`) or `hz_rd_i` (`hz_we_i`).
- During a hazard stall, a bubble is written to the outputs (`valid_o`=0, all enables 0).
- `stall_o` is also 1 whenever `stall_i`=1. In that case the outputs hold.
- Branch taken: BEQ with rs1==rs2 data, BNE with rs1≠rs2 data, or JMP. `branch_o`=1 and `branch_addr_o`=target, combinational, only when not stalled.
  - States: RUN → SQUASH on a taken branch at the clock edge; SQUASH → RUN after one unstalled cycle.
  - In SQUASH, the wrong-path word on `inst_i` is discarded: bubble, no branch, no hazard.
  - Branches/JMP pass to execute with reg_we=mem_re=mem_we=0 and `valid_o`=1.

## Timing
- Reset (rst=0, async): all outputs 0, state RUN, register file cleared to 0.
- Latency 1: an instruction decoded in cycle n appears on the output bundle after the edge ending cycle n.
- `branch_o`/`stall_o` are valid in the same cycle as `inst_i`. `ifetch` samples them at the next edge.
- Taken branch costs exactly 1 bubble. Load-use costs exactly 1 bubble. Branch operand hazards stall until clear.
- Simultaneous `stall_i` and a taken branch: `stall_i` wins. `branch_o`=0 until `stall_i` drops.
- Reset mid-SQUASH returns to RUN and clears outputs immediately.

## Test plan
- Reset then release: all outputs 0. ADDI r1,r0,5 at addr 0 → next cycle `valid_o`=1, rd_o=1, imm_o=5, reg_we_o=1, pc_o=0.
- Writeback r2=0x1234 with same-cycle ADD r3,r2,r0 → rs1_data_o=0x1234 (bypass). A write to r0 → reads stay 0.
- LD r4 then ADD r5,r4,r4 → `stall_o`=1 for one cycle, a bubble emitted, then ADD issued with `inst_i` held.
- BEQ r0,r0,+3 at addr 0x10 → `branch_o`=1, `branch_addr_o`=0x14. The following word is squashed (`valid_o`=0), then the instruction at 0x14 decodes.
- BNE r6,r7 with `hz_we_i`=1, `hz_rd_i`=6 → `stall_o`=1, `branch_o`=0 until `hz_we_i`=0.
- Opcode 0x3F → `illegal_o`=1, all enables 0. Asserting rst mid-SQUASH → outputs 0 immediately.
